// File: rtl/circuit2_hlsm_pkg.sv
// Shared types and constants for the scheduled d/e/f compare-select-shift engine.
package circuit2_hlsm_pkg;

  localparam int DATAWIDTH_DEFAULT = 32;
  localparam int WIDTH_DEFAULT     = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S1    = 3'd1,
    S2    = 3'd2,
    S3    = 3'd3,
    S4    = 3'd4,
    S5    = 3'd5,
    S6    = 3'd6,
    FINAL = 3'd7
  } state_t;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } alu_mode_t;

endpackage

// File: rtl/circuit2_hlsm_if.sv
// Start/Done handshake, operand and result bundle between the sequencer and the engine.
interface circuit2_hlsm_if #(
  parameter int DATAWIDTH = circuit2_hlsm_pkg::DATAWIDTH_DEFAULT,
  parameter int WIDTH     = circuit2_hlsm_pkg::WIDTH_DEFAULT
);

  logic                 Start;
  logic [DATAWIDTH-1:0] a;
  logic [DATAWIDTH-1:0] b;
  logic [DATAWIDTH-1:0] c;
  logic                 Busy;
  logic                 Done;
  logic [WIDTH-1:0]     dLTe;
  logic [WIDTH-1:0]     dEQe;
  logic [DATAWIDTH-1:0] g;
  logic [DATAWIDTH-1:0] h;
  logic [DATAWIDTH-1:0] x;
  logic [DATAWIDTH-1:0] z;

  modport master (
    output Start, a, b, c,
    input  Busy, Done, dLTe, dEQe, g, h, x, z
  );

  modport slave (
    input  Start, a, b, c,
    output Busy, Done, dLTe, dEQe, g, h, x, z
  );

endinterface

// File: rtl/circuit2_hlsm_alu.sv
// Shared adder/subtractor; one instance serves every arithmetic state of the schedule.
module hlsm_alu
  import circuit2_hlsm_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEFAULT
) (
  input  logic [DATAWIDTH-1:0] op1,
  input  logic [DATAWIDTH-1:0] op2,
  input  alu_mode_t            mode,
  output logic [DATAWIDTH-1:0] result
);

  always_comb begin
    result = (mode == ALU_SUB) ? (op1 - op2) : (op1 + op2);
  end

endmodule

// File: rtl/circuit2_hlsm.sv
// Multi-cycle d/e/f compare-select-shift engine: FSM controller plus a datapath
// that time-shares a single ALU; results match the combinational graph bit for bit.
module circuit2_hlsm
  import circuit2_hlsm_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEFAULT,
  parameter int WIDTH     = WIDTH_DEFAULT
) (
  input logic            Clk,
  input logic            Rst,
  circuit2_hlsm_if.slave bus
);

  state_t state;
  state_t state_next;

  logic [DATAWIDTH-1:0] reg_a, reg_b, reg_c;
  logic [DATAWIDTH-1:0] d, e, f;
  logic [DATAWIDTH-1:0] g, h, x, z;
  logic [WIDTH-1:0]     dlte, deqe;

  alu_mode_t            alu_mode;
  logic                 alu_sel_c;
  logic [DATAWIDTH-1:0] alu_result;
  logic                 busy, done;
  logic                 d_lt_e;

  // State register.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    if (!Rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    state_next = state;
    case (state)
      IDLE:    if (bus.Start) state_next = S1;
      S1:      state_next = S2;
      S2:      state_next = S3;
      S3:      state_next = S4;
      S4:      state_next = S5;
      S5:      state_next = S6;
      S6:      state_next = FINAL;
      FINAL:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: handshake status and ALU control, straight from the state.
  always_comb begin
    busy      = (state != IDLE);
    done      = (state == FINAL);
    alu_mode  = ALU_ADD;
    alu_sel_c = 1'b0;
    case (state)
      S2:      alu_sel_c = 1'b1;
      S3:      alu_mode  = ALU_SUB;
      default: ;
    endcase
  end

  // Operand one is always A; operand two is C only while computing e.
  hlsm_alu #(
    .DATAWIDTH(DATAWIDTH)
  ) u_alu (
    .op1    (reg_a),
    .op2    (alu_sel_c ? reg_c : reg_b),
    .mode   (alu_mode),
    .result (alu_result)
  );

  assign d_lt_e = (d < e);

  // Datapath registers; each is written on the edge that leaves its scheduled state.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      reg_a <= '0;
      reg_b <= '0;
      reg_c <= '0;
      d     <= '0;
      e     <= '0;
      f     <= '0;
      g     <= '0;
      h     <= '0;
      x     <= '0;
      z     <= '0;
      dlte  <= '0;
      deqe  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            reg_a <= bus.a;
            reg_b <= bus.b;
            reg_c <= bus.c;
          end
        end
        S1: d <= alu_result;
        S2: e <= alu_result;
        S3: begin
          f    <= alu_result;
          dlte <= WIDTH'(d_lt_e);
          deqe <= WIDTH'(!d_lt_e);
        end
        S4: g <= (dlte != '0) ? d : e;
        S5: begin
          h <= (deqe != '0) ? g : f;
          x <= g << dlte;
        end
        S6: z <= h >> deqe;
        default: ;
      endcase
    end
  end

  assign bus.Busy = busy;
  assign bus.Done = done;
  assign bus.dLTe = dlte;
  assign bus.dEQe = deqe;
  assign bus.g    = g;
  assign bus.h    = h;
  assign bus.x    = x;
  assign bus.z    = z;

endmodule

// File: tb/tb_circuit2_hlsm.sv
// Directed and random checks of circuit2_hlsm against hand-computed values and a
// golden combinational model of the d/e/f graph.
module tb_circuit2_hlsm;

  localparam int DW = 32;
  localparam int FW = 2;

  logic Clk;
  logic Rst;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] obs   [6];
  logic [DW-1:0] exp_v [6];
  string         nm    [6] = '{"dLTe", "dEQe", "g", "h", "x", "z"};

  circuit2_hlsm_if #(.DATAWIDTH(DW), .WIDTH(FW)) bus ();

  circuit2_hlsm #(.DATAWIDTH(DW), .WIDTH(FW)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic capture();
    obs[0] = DW'(bus.dLTe);
    obs[1] = DW'(bus.dEQe);
    obs[2] = bus.g;
    obs[3] = bus.h;
    obs[4] = bus.x;
    obs[5] = bus.z;
  endtask

  task automatic set_expected(input logic [DW-1:0] lt, eq, g, h, x, z);
    exp_v[0] = lt;
    exp_v[1] = eq;
    exp_v[2] = g;
    exp_v[3] = h;
    exp_v[4] = x;
    exp_v[5] = z;
  endtask

  // Combinational golden model of the graph, written out per branch.
  task automatic golden(input logic [DW-1:0] a, b, c);
    logic [DW-1:0] d, e, f;
    d = a + b;
    e = a + c;
    f = a - b;
    if (d < e) set_expected(1, 0, d, f, {d[DW-2:0], 1'b0}, f);
    else       set_expected(0, 1, e, e, e, {1'b0, e[DW-1:1]});
  endtask

  // Called just after an edge in IDLE; returns just after the accepting edge.
  task automatic start_run(input logic [DW-1:0] a, b, c);
    bus.a     = a;
    bus.b     = b;
    bus.c     = c;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.Done) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) begin
      checks++;
      errors++;
      $display("FAIL %s.done_timeout: Done not seen within 20 cycles", name);
    end
  endtask

  task automatic test_reset();
    Rst       = 1'b0;
    bus.Start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.c     = '0;
    tick();
    tick();
    capture();
    set_expected(0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset.Busy: got %b expected 0", bus.Busy);
    end
    checks++;
    if (bus.Done !== 1'b0) begin
      errors++;
      $display("FAIL reset.Done: got %b expected 0", bus.Done);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (obs[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL reset.%s: got %h expected %h", nm[k], obs[k], exp_v[k]);
      end
    end
    Rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int busy_cnt, done_cnt, done_at;
    start_run(32'd10, 32'd3, 32'd5);
    busy_cnt = bus.Busy ? 1 : 0;
    done_cnt = 0;
    done_at  = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bus.Busy) busy_cnt++;
      if (bus.Done) begin
        done_cnt++;
        done_at = i;
        capture();
      end
    end
    // Done is visible right after edge N+6 and drops at N+7.
    checks++;
    if (done_at !== 6 || done_cnt !== 1) begin
      errors++;
      $display("FAIL basic.latency: got done_at=%0d pulses=%0d expected done_at=6 pulses=1",
               done_at, done_cnt);
    end
    checks++;
    if (busy_cnt !== 7) begin
      errors++;
      $display("FAIL basic.busy_cycles: got %0d expected 7", busy_cnt);
    end
    set_expected(1, 0, 13, 7, 26, 7);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (obs[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL basic.%s: got %h expected %h", nm[k], obs[k], exp_v[k]);
      end
    end
  endtask

  task automatic test_vector(input string name, input logic [DW-1:0] a, b, c,
                             input logic [DW-1:0] lt, eq, g, h, x, z);
    int cyc;
    start_run(a, b, c);
    wait_done(name, cyc);
    capture();
    set_expected(lt, eq, g, h, x, z);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (obs[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL %s.%s: got %h expected %h", name, nm[k], obs[k], exp_v[k]);
      end
    end
    tick();
  endtask

  task automatic test_handshake();
    int cyc, busy_seen, ndone, first_gap_bad;
    int done_t [4];
    start_run(32'd10, 32'd3, 32'd5);
    tick();                                  // now in S2
    bus.Start = 1'b1; bus.a = 1; bus.b = 1; bus.c = 1;
    tick();                                  // S3
    bus.Start = 1'b0;
    tick();                                  // S4
    bus.Start = 1'b1;
    tick();                                  // S5
    bus.Start = 1'b0;
    wait_done("handshake", cyc);
    capture();
    set_expected(1, 0, 13, 7, 26, 7);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (obs[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL handshake.%s: got %h expected %h", nm[k], obs[k], exp_v[k]);
      end
    end
    busy_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.Busy) busy_seen++;
    end
    checks++;
    if (busy_seen !== 0) begin
      errors++;
      $display("FAIL handshake.no_relaunch: got %0d busy cycles expected 0", busy_seen);
    end

    // Start held high: a new run launches on every IDLE visit.
    bus.a = 10; bus.b = 5; bus.c = 5;
    bus.Start = 1'b1;
    ndone = 0;
    for (int i = 1; i <= 40 && ndone < 4; i++) begin
      tick();
      if (bus.Done) begin
        done_t[ndone] = i;
        ndone++;
      end
    end
    bus.Start = 1'b0;
    tick();
    checks++;
    if (ndone !== 4) begin
      errors++;
      $display("FAIL held_start.pulses: got %0d expected 4", ndone);
    end else begin
      first_gap_bad = 0;
      for (int i = 1; i < 4; i++)
        if (done_t[i] - done_t[i-1] != 8) first_gap_bad++;
      if (first_gap_bad != 0) begin
        errors++;
        $display("FAIL held_start.interval: got gaps %0d,%0d,%0d expected 8,8,8",
                 done_t[1] - done_t[0], done_t[2] - done_t[1], done_t[3] - done_t[2]);
      end
    end
  endtask

  task automatic test_midrun_reset();
    int dones;
    start_run(32'd1, 32'd2, 32'd3);
    tick();                                  // S2
    tick();                                  // S3
    Rst = 1'b0;
    tick();
    capture();
    set_expected(0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset.status: got Busy=%b Done=%b expected 0 0", bus.Busy, bus.Done);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (obs[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL midrun_reset.%s: got %h expected %h", nm[k], obs[k], exp_v[k]);
      end
    end
    Rst = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.Done || bus.Busy) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL midrun_reset.aborted: got %0d active cycles expected 0", dones);
    end
    test_vector("after_reset", 32'hFFFF_FFFF, 32'd1, 32'd2,
                1, 0, 0, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFE);
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [DW-1:0] ra, rb, rc;
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = $urandom;
      rc = (n % 7 == 0) ? rb : $urandom;
      if (n % 11 == 0) ra = 32'hFFFF_FFFF - (ra & 32'hF);
      start_run(ra, rb, rc);
      wait_done("random", cyc);
      capture();
      golden(ra, rb, rc);
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (obs[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL random[%0d].%s: a=%h b=%h c=%h got %h expected %h",
                   n, nm[k], ra, rb, rc, obs[k], exp_v[k]);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vector("not_less", 32'd10, 32'd5, 32'd5, 0, 1, 15, 15, 15, 7);
    test_vector("wrap", 32'hFFFF_FFFF, 32'd1, 32'd2, 1, 0, 0, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFE);
    test_handshake();
    test_midrun_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
